// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multi-cycle CPU control FSM: opcodes, ALU
// operation codes, FSM state encodings and the bundled control-output struct.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned ST_W  = 4;

    localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPC_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPC_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPC_W-1:0] OP_J     = 6'b111000;
    localparam logic [OPC_W-1:0] OP_HALT  = 6'b111111;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLL = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b100;

    localparam logic [ST_W-1:0] S_IF      = 4'd0;
    localparam logic [ST_W-1:0] S_ID      = 4'd1;
    localparam logic [ST_W-1:0] S_EXE_ALU = 4'd2;
    localparam logic [ST_W-1:0] S_WB_ALU  = 4'd3;
    localparam logic [ST_W-1:0] S_EXE_BR  = 4'd4;
    localparam logic [ST_W-1:0] S_EXE_MEM = 4'd5;
    localparam logic [ST_W-1:0] S_MEM     = 4'd6;
    localparam logic [ST_W-1:0] S_WB_LD   = 4'd7;
    localparam logic [ST_W-1:0] S_HALT    = 4'd8;

    typedef struct packed {
        logic             pc_wre;
        logic             ir_wre;
        logic             ins_mem_rw;
        logic             alu_src_a;
        logic             alu_src_b;
        logic             db_data_src;
        logic             reg_wre;
        logic             m_rd;
        logic             m_wr;
        logic             ext_sel;
        logic [1:0]       reg_dst;
        logic [1:0]       pc_src;
        logic [ALU_W-1:0] alu_op;
        logic             halted;
    } ctrl_t;

    function automatic logic [ALU_W-1:0] alu_op_of(input logic [OPC_W-1:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE: return ALU_SUB;
            OP_AND, OP_ANDI:        return ALU_AND;
            OP_ORI:                 return ALU_OR;
            OP_SLL:                 return ALU_SLL;
            default:                return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, opcode, zero) into datapath controls and the next FSM state.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [ST_W-1:0]  state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output ctrl_t            ctrl,
    output logic [ST_W-1:0]  state_nxt
);

    logic is_rtype, is_alui, is_mem, is_br, taken;

    always_comb begin
        is_rtype = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_SLL};
        is_alui  = opcode inside {OP_ADDIU, OP_ANDI, OP_ORI};
        is_mem   = opcode inside {OP_SW, OP_LW};
        is_br    = opcode inside {OP_BEQ, OP_BNE};
        taken    = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

        ctrl      = '0;
        state_nxt = S_IF;

        // Selects are held constant from ID to the final state so writes never see a glitch.
        if (state != S_IF && state != S_HALT) begin
            ctrl.alu_src_a   = (opcode == OP_SLL);
            ctrl.alu_src_b   = is_alui || is_mem;
            ctrl.ext_sel     = !(opcode inside {OP_ANDI, OP_ORI});
            ctrl.reg_dst     = is_rtype ? 2'b01 : 2'b00;
            ctrl.alu_op      = alu_op_of(opcode);
            ctrl.db_data_src = (opcode == OP_LW);
        end

        case (state)
            S_IF: begin
                ctrl.ir_wre     = 1'b1;
                ctrl.ins_mem_rw = 1'b1;
                state_nxt       = S_ID;
            end
            S_ID: begin
                if (opcode == OP_J) begin
                    ctrl.pc_wre = 1'b1;
                    ctrl.pc_src = 2'b10;
                end else if (opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                end else if (is_br) begin
                    state_nxt = S_EXE_BR;
                end else if (is_mem) begin
                    state_nxt = S_EXE_MEM;
                end else if (is_rtype || is_alui) begin
                    state_nxt = S_EXE_ALU;
                end else begin
                    ctrl.pc_wre = 1'b1;
                end
            end
            S_EXE_ALU: state_nxt = S_WB_ALU;
            S_WB_ALU: begin
                ctrl.reg_wre = 1'b1;
                ctrl.pc_wre  = 1'b1;
            end
            S_EXE_BR: begin
                ctrl.pc_wre = 1'b1;
                ctrl.pc_src = taken ? 2'b01 : 2'b00;
            end
            S_EXE_MEM: state_nxt = S_MEM;
            S_MEM: begin
                if (opcode == OP_LW) begin
                    ctrl.m_rd = 1'b1;
                    state_nxt = S_WB_LD;
                end else begin
                    ctrl.m_wr   = (opcode == OP_SW);
                    ctrl.pc_wre = 1'b1;
                end
            end
            S_WB_LD: begin
                ctrl.reg_wre = 1'b1;
                ctrl.pc_wre  = 1'b1;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
                state_nxt   = S_HALT;
            end
            default: state_nxt = S_IF;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control FSM: state register plus an optional retired-instruction
// counter, built only when PERF_CNT_EN is defined.
module multi_cycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                zero,
    output logic                PCWre,
    output logic                IRWre,
    output logic                InsMemRW,
    output logic                ALUSrcA,
    output logic                ALUSrcB,
    output logic                DBDataSrc,
    output logic                RegWre,
    output logic                mRD,
    output logic                mWR,
    output logic                ExtSel,
    output logic [1:0]          RegDst,
    output logic [1:0]          PCSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [3:0]          state,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_retired
);

    logic [ST_W-1:0] state_q, state_d;
    ctrl_t           ctrl;

    ctrl_decode u_decode (
        .state     (state_q),
        .opcode    (Opcode),
        .zero      (zero),
        .ctrl      (ctrl),
        .state_nxt (state_d)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    assign PCWre     = ctrl.pc_wre;
    assign IRWre     = ctrl.ir_wre;
    assign InsMemRW  = ctrl.ins_mem_rw;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign DBDataSrc = ctrl.db_data_src;
    assign RegWre    = ctrl.reg_wre;
    assign mRD       = ctrl.m_rd;
    assign mWR       = ctrl.m_wr;
    assign ExtSel    = ctrl.ext_sel;
    assign RegDst    = ctrl.reg_dst;
    assign PCSrc     = ctrl.pc_src;
    assign ALUOp     = ctrl.alu_op;
    assign state     = state_q;
    assign halted    = ctrl.halted;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, ctrl.pc_wre};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign instr_retired = cnt_q;
`else
    assign instr_retired = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: per-phase instruction model plus literal spot checks.
module tb_multi_cycle_control;
    import cpu_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [5:0]  Opcode = '0;
    logic        zero = 1'b0;
    logic        PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc, RegWre;
    logic        mRD, mWR, ExtSel, halted;
    logic [1:0]  RegDst, PCSrc;
    logic [2:0]  ALUOp;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    multi_cycle_control dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .Opcode        (Opcode),
        .zero          (zero),
        .PCWre         (PCWre),
        .IRWre         (IRWre),
        .InsMemRW      (InsMemRW),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .DBDataSrc     (DBDataSrc),
        .RegWre        (RegWre),
        .mRD           (mRD),
        .mWR           (mWR),
        .ExtSel        (ExtSel),
        .RegDst        (RegDst),
        .PCSrc         (PCSrc),
        .ALUOp         (ALUOp),
        .state         (state),
        .halted        (halted),
        .instr_retired (instr_retired)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwre, irwre, insmem, srca, srcb, dbsrc, regwre, mrd, mwr, ext;
        logic [1:0] regdst, pcsrc;
        logic [2:0] aluop;
        logic       halted;
    } vec_t;

    vec_t got;
    assign got = {state, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc, RegWre,
                  mRD, mWR, ExtSel, RegDst, PCSrc, ALUOp, halted};

    int   n_checks = 0;
    int   n_fail = 0;
    int   cnt_model = 0;
    bit   chk_en = 1'b0;
    vec_t exp_v;
    vec_t samp[8];

    function automatic bit is_rtype(input logic [5:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_SLL;
    endfunction

    function automatic bit is_imm(input logic [5:0] op);
        return op == OP_ADDIU || op == OP_ANDI || op == OP_ORI;
    endfunction

    function automatic int n_phases(input logic [5:0] op);
        if (op == OP_BEQ || op == OP_BNE) return 3;
        if (op == OP_LW) return 5;
        if (op == OP_SW || is_rtype(op) || is_imm(op)) return 4;
        return 2;
    endfunction

    function automatic logic [2:0] alu_fn(input logic [5:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE: return 3'b001;
            OP_SLL:                 return 3'b010;
            OP_ORI:                 return 3'b011;
            OP_AND, OP_ANDI:        return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    // Expected outputs for phase k (0 = fetch) of an instruction.
    function automatic vec_t model(input logic [5:0] op, input logic z, input int k);
        vec_t v;
        bit   br, mem, act, last;
        v    = '0;
        br   = (op == OP_BEQ) || (op == OP_BNE);
        mem  = (op == OP_SW) || (op == OP_LW);
        if (k == 0)                v.st = S_IF;
        else if (k == 1)           v.st = S_ID;
        else if (op == OP_HALT)    v.st = S_HALT;
        else if (br)               v.st = S_EXE_BR;
        else if (mem)              v.st = (k == 2) ? S_EXE_MEM : (k == 3) ? S_MEM : S_WB_LD;
        else                       v.st = (k == 2) ? S_EXE_ALU : S_WB_ALU;
        last     = (k == n_phases(op) - 1) && (op != OP_HALT);
        act      = (k >= 1) && (v.st != S_HALT);
        v.irwre  = (k == 0);
        v.insmem = (k == 0);
        v.pcwre  = last;
        v.halted = (v.st == S_HALT);
        if (act) begin
            v.srca   = (op == OP_SLL);
            v.srcb   = is_imm(op) || mem;
            v.ext    = !(op == OP_ANDI || op == OP_ORI);
            v.regdst = is_rtype(op) ? 2'b01 : 2'b00;
            v.aluop  = alu_fn(op);
            v.dbsrc  = (op == OP_LW);
        end
        v.regwre = last && (is_rtype(op) || is_imm(op) || op == OP_LW);
        v.mrd    = (k == 3) && (op == OP_LW);
        v.mwr    = (k == 3) && (op == OP_SW);
        if (op == OP_J && k == 1) v.pcsrc = 2'b10;
        if (br && k == 2 && ((op == OP_BEQ) == z)) v.pcsrc = 2'b01;
        return v;
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef PERF_CNT_EN
        return 32'(cnt_model);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One cycle: compare at the falling edge, then advance to just after the rising edge.
    task automatic tick(input int k);
        @(negedge CLK);
        if (chk_en) begin
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL outputs op=%b phase=%0d: got %h, expected %h", Opcode, k, got, exp_v);
            end
            n_checks++;
            if (instr_retired !== exp_cnt()) begin
                n_fail++;
                $display("FAIL instr_retired op=%b phase=%0d: got %0d, expected %0d",
                         Opcode, k, instr_retired, exp_cnt());
            end
        end
        samp[k] = got;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, output int cycles);
        Opcode = op;
        zero   = z;
        cycles = 0;
        chk_en = 1'b1;
        for (int k = 0; k < n_phases(op); k++) begin
            exp_v = model(op, z, k);
            tick(k);
            if (samp[k].pcwre && cycles == 0) cycles = k + 1;
            if (exp_v.pcwre) cnt_model++;
        end
    endtask

    initial begin
        int   cyc;
        vec_t rv;

        // Reset held low: only the fetch strobes are active.
        #2;
        rv        = '0;
        rv.st     = S_IF;
        rv.irwre  = 1'b1;
        rv.insmem = 1'b1;
        check_lit("reset_outputs", 32'(got), 32'(rv));
        check_lit("reset_retired", instr_retired, 32'd0);
        @(posedge CLK);
        #1;
        check_lit("reset_hold_state", 32'(state), 32'(S_IF));
        Reset = 1'b1;

        run_instr(OP_ADD, 1'b0, cyc);
        check_lit("add_cycles", 32'(cyc), 32'd4);
        check_lit("add_wb_regdst", 32'(samp[3].regdst), 32'b01);
        check_lit("add_wb_regwre", 32'(samp[3].regwre), 32'd1);
        check_lit("add_exe_regwre", 32'(samp[2].regwre), 32'd0);
        run_instr(OP_ADDIU, 1'b0, cyc);
        run_instr(OP_ANDI, 1'b1, cyc);
        check_lit("andi_extsel", 32'(samp[2].ext), 32'd0);
        run_instr(OP_ORI, 1'b0, cyc);
        run_instr(OP_SLL, 1'b0, cyc);
        check_lit("sll_srca", 32'(samp[2].srca), 32'd1);
        run_instr(OP_SUB, 1'b1, cyc);
        run_instr(OP_AND, 1'b0, cyc);

        run_instr(OP_BEQ, 1'b1, cyc);
        check_lit("beq_taken_cycles", 32'(cyc), 32'd3);
        check_lit("beq_taken_pcsrc", 32'(samp[2].pcsrc), 32'b01);
        check_lit("beq_aluop", 32'(samp[2].aluop), 32'b001);
        run_instr(OP_BEQ, 1'b0, cyc);
        check_lit("beq_nt_pcsrc", 32'(samp[2].pcsrc), 32'b00);
        run_instr(OP_BNE, 1'b0, cyc);
        check_lit("bne_taken_pcsrc", 32'(samp[2].pcsrc), 32'b01);
        run_instr(OP_BNE, 1'b1, cyc);
        check_lit("bne_nt_pcsrc", 32'(samp[2].pcsrc), 32'b00);

        run_instr(OP_LW, 1'b0, cyc);
        check_lit("lw_cycles", 32'(cyc), 32'd5);
        check_lit("lw_mem_mrd", 32'(samp[3].mrd), 32'd1);
        check_lit("lw_wb_dbsrc", 32'(samp[4].dbsrc), 32'd1);
        check_lit("lw_wb_regdst", 32'(samp[4].regdst), 32'b00);
        run_instr(OP_SW, 1'b0, cyc);
        check_lit("sw_cycles", 32'(cyc), 32'd4);
        run_instr(OP_J, 1'b0, cyc);
        check_lit("j_cycles", 32'(cyc), 32'd2);
        check_lit("j_pcsrc", 32'(samp[1].pcsrc), 32'b10);

        // Reset asserted in the middle of an SW's memory cycle.
        Opcode = OP_SW;
        zero   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_v = model(OP_SW, 1'b0, k);
            tick(k);
        end
        chk_en = 1'b0;
        #1;
        check_lit("sw_mem_mwr_before_reset", 32'(mWR), 32'd1);
        Reset = 1'b0;
        #1;
        check_lit("abort_state", 32'(state), 32'(S_IF));
        check_lit("abort_mwr", 32'(mWR), 32'd0);
        check_lit("abort_pcwre", 32'(PCWre), 32'd0);
        check_lit("abort_retired_cleared", instr_retired, 32'd0);
        @(posedge CLK);
        #1;
        check_lit("abort_state_after_edge", 32'(state), 32'(S_IF));
        Reset     = 1'b1;
        cnt_model = 0;

        run_instr(OP_ADD, 1'b0, cyc);
        run_instr(OP_SW, 1'b0, cyc);
        run_instr(OP_J, 1'b0, cyc);
        run_instr(6'b101010, 1'b0, cyc);
        check_lit("nop_cycles", 32'(cyc), 32'd2);
`ifdef PERF_CNT_EN
        check_lit("retired_after_four", instr_retired, 32'd4);
`else
        check_lit("retired_tied_zero", instr_retired, 32'd0);
`endif

        run_instr(OP_HALT, 1'b0, cyc);
        exp_v = model(OP_HALT, 1'b0, 2);
        for (int i = 0; i < 20; i++) tick(2);
        check_lit("halted_flag", 32'(halted), 32'd1);
        check_lit("halt_state", 32'(state), 32'(S_HALT));
        chk_en = 1'b0;
        Reset  = 1'b0;
        #1;
        check_lit("halt_exit_state", 32'(state), 32'(S_IF));
        check_lit("halt_exit_halted", 32'(halted), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
